// File: rtl/display_pkg.sv
// display_pkg: shared state encoding and digit-select constants for the display scan controller
package display_pkg;
    typedef enum logic [1:0] {SHOW_A, PEND_B, SHOW_B} state_e;
    localparam logic [3:0] SEL_SLOT0 = 4'b0111;
    localparam logic [3:0] SEL_SLOT1 = 4'b1011;
    localparam logic [3:0] SEL_SLOT2 = 4'b1101;
    localparam logic [3:0] SEL_SLOT3 = 4'b1110;
    localparam logic [3:0] SEL_OFF   = 4'b1111;
    function automatic logic [3:0] sel_for(input logic [1:0] slot);
        return slot == 2'd0 ? SEL_SLOT0 : slot == 2'd1 ? SEL_SLOT1 : slot == 2'd2 ? SEL_SLOT2 : SEL_SLOT3;
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: divides the system clock into digit slots, strobing tick_o in the last cycle of each slot
module scan_prescaler #(
    parameter int CLK_DIV = 250000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] cnt_q;
    assign tick_o = cnt_q == W'(CLK_DIV - 1);
    always_ff @(posedge clk_i)
        if (!rst_n_i) cnt_q <= '0;
        else cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit scan, main/overlay source arbitration, leading-zero blanking and blink
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLK_DIV      = 250000,
    parameter int BLINK_FRAMES = 50,
    parameter int HOLD_FRAMES  = 200
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] a_bcd_i,
    input  logic [3:0]  a_dp_i,
    input  logic        b_req_i,
    input  logic [15:0] b_bcd_i,
    input  logic [3:0]  b_dp_i,
    input  logic        lz_en_i,
    input  logic [3:0]  blink_i,
    output logic [3:0]  sel_o,
    output logic [3:0]  bcd_o,
    output logic        dp_o,
    output logic        tick_o,
    output logic        b_busy_o
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_cnt_q;
    logic          phase_q, busy_q, tick_q, dp_q, dp_d;
    logic [1:0]    slot_q;
    logic [15:0]   snap_bcd_q, src_bcd;
    logic [3:0]    snap_dp_q, src_dp, nz, sel_q, sel_d, bcd_q, bcd_d;
    logic          tick, frame_end, blink_wrap, blank;
    scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .tick_o (tick)
    );
    assign frame_end  = tick && slot_q == 2'd3;
    assign blink_wrap = blink_cnt_q == BW'(BLINK_FRAMES - 1);
    // a request in SHOW_B restarts the hold even on the frame end that would expire it
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            SHOW_A: state_d = b_req_i ? PEND_B : SHOW_A;
            PEND_B: if (frame_end) begin
                state_d = SHOW_B;
                hold_d  = '0;
            end
            SHOW_B: if (b_req_i) hold_d = '0;
                else if (frame_end) begin
                    state_d = hold_q == HW'(HOLD_FRAMES - 1) ? SHOW_A : SHOW_B;
                    hold_d  = hold_q + 1'b1;
                end
            default: state_d = SHOW_A;
        endcase
    end
    always_comb begin
        src_bcd = state_q == SHOW_B ? snap_bcd_q : a_bcd_i;
        src_dp  = state_q == SHOW_B ? snap_dp_q : a_dp_i;
        for (int k = 0; k < 4; k++) nz[k] = |src_bcd[4*k +: 4] | src_dp[k];
        blank = (lz_en_i && slot_q != 2'd0 && ~|(nz >> slot_q)) ||
                (phase_q && state_q != SHOW_B && blink_i[slot_q]);
        sel_d = blank ? SEL_OFF : sel_for(slot_q);
        bcd_d = src_bcd[{slot_q, 2'b00} +: 4];
        dp_d  = !blank && src_dp[slot_q];
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= SHOW_A;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            slot_q      <= 2'd0;
            snap_bcd_q  <= '0;
            snap_dp_q   <= '0;
            sel_q       <= SEL_OFF;
            bcd_q       <= '0;
            dp_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            busy_q  <= state_d != SHOW_A;
            tick_q  <= tick;
            if (b_req_i) begin
                snap_bcd_q <= b_bcd_i;
                snap_dp_q  <= b_dp_i;
            end
            if (tick) begin
                sel_q  <= sel_d;
                bcd_q  <= bcd_d;
                dp_q   <= dp_d;
                slot_q <= slot_q + 1'b1;
            end
            if (frame_end) begin
                blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
                phase_q     <= phase_q ^ blink_wrap;
            end
        end
    end
    assign sel_o    = sel_q;
    assign bcd_o    = bcd_q;
    assign dp_o     = dp_q;
    assign tick_o   = tick_q;
    assign b_busy_o = busy_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for the scan controller with CLK_DIV=4, BLINK_FRAMES=2, HOLD_FRAMES=3
`timescale 1ns/1ps
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] a_bcd_i = '0, b_bcd_i = '0;
    logic [3:0]  a_dp_i = '0, b_dp_i = '0, blink_i = '0;
    logic        b_req_i = 1'b0, lz_en_i = 1'b0;
    logic [3:0]  sel_o, bcd_o;
    logic        dp_o, tick_o, b_busy_o;
    typedef struct packed {logic [3:0] sel; logic [3:0] bcd; logic dp; logic busy;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0, slot = 0, frame = 0;
    always #5 clk = ~clk;
    display_scan_ctrl #(.CLK_DIV(4), .BLINK_FRAMES(2), .HOLD_FRAMES(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .a_bcd_i(a_bcd_i), .a_dp_i(a_dp_i),
        .b_req_i(b_req_i), .b_bcd_i(b_bcd_i), .b_dp_i(b_dp_i), .lz_en_i(lz_en_i),
        .blink_i(blink_i), .sel_o(sel_o), .bcd_o(bcd_o), .dp_o(dp_o),
        .tick_o(tick_o), .b_busy_o(b_busy_o)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic push(input logic [3:0] s, input logic [3:0] b, input logic d, input logic y);
        q.push_back({s, b, d, y});
    endtask
    task automatic push_frame(input logic [15:0] v, input logic y, input logic y_last);
        push(4'b0111, v[3:0], 1'b0, y);
        push(4'b1011, v[7:4], 1'b0, y);
        push(4'b1101, v[11:8], 1'b0, y);
        push(4'b1110, v[15:12], 1'b0, y_last);
    endtask
    task automatic next_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_o && n < 20);
        check("period", cyc, 4);
        cyc = 0;
    endtask
    task automatic advance();
        slot = (slot + 1) % 4;
        if (slot == 0) frame++;
    endtask
    task automatic tick_check();
        exp_t e;
        next_tick();
        if (q.size() == 0) check("queue_empty", 1, 0);
        else begin
            e = q.pop_front();
            check($sformatf("slot%0d_frame%0d", slot, frame), {sel_o, bcd_o, dp_o, b_busy_o}, e);
        end
        advance();
    endtask
    task automatic drain();
        while (q.size() > 0) tick_check();
    endtask
    task automatic sync(input int mod);
        while (slot != 0 || frame % mod != 0) begin
            next_tick();
            advance();
        end
    endtask
    task automatic do_reset(input int n);
        rst_n_i = 1'b0;
        repeat (n) step();
        check("rst_sel", sel_o, 4'b1111);
        check("rst_bcd", bcd_o, 0);
        check("rst_dp", dp_o, 0);
        check("rst_tick", tick_o, 0);
        check("rst_busy", b_busy_o, 0);
        rst_n_i = 1'b1;
        cyc = 0;
        slot = 0;
        frame = 0;
    endtask
    task automatic req(input logic [15:0] v);
        b_req_i = 1'b1;
        b_bcd_i = v;
        step();
        b_req_i = 1'b0;
        check("busy_rise", b_busy_o, 1);
    endtask
    initial begin
        a_bcd_i = 16'h1234;
        a_dp_i  = 4'b0100;
        do_reset(10);
        repeat (2) begin
            push(4'b0111, 4'h4, 1'b0, 1'b0);
            push(4'b1011, 4'h3, 1'b0, 1'b0);
            push(4'b1101, 4'h2, 1'b1, 1'b0);
            push(4'b1110, 4'h1, 1'b0, 1'b0);
        end
        drain();
        // leading-zero blanking
        lz_en_i = 1'b1;
        a_bcd_i = 16'h0050;
        a_dp_i  = 4'b0000;
        push(4'b0111, 4'h0, 1'b0, 1'b0);
        push(4'b1011, 4'h5, 1'b0, 1'b0);
        push(4'b1111, 4'h0, 1'b0, 1'b0);
        push(4'b1111, 4'h0, 1'b0, 1'b0);
        drain();
        a_bcd_i = 16'h0000;
        push(4'b0111, 4'h0, 1'b0, 1'b0);
        repeat (3) push(4'b1111, 4'h0, 1'b0, 1'b0);
        drain();
        a_dp_i = 4'b0100;
        push(4'b0111, 4'h0, 1'b0, 1'b0);
        push(4'b1011, 4'h0, 1'b0, 1'b0);
        push(4'b1101, 4'h0, 1'b1, 1'b0);
        push(4'b1111, 4'h0, 1'b0, 1'b0);
        drain();
        // blink on digit 0, aligned to the blink cycle
        lz_en_i = 1'b0;
        a_dp_i  = 4'b0000;
        a_bcd_i = 16'h1234;
        blink_i = 4'b0001;
        sync(4);
        for (int f = 0; f < 4; f++) begin
            push(f < 2 ? 4'b0111 : 4'b1111, 4'h4, 1'b0, 1'b0);
            push(4'b1011, 4'h3, 1'b0, 1'b0);
            push(4'b1101, 4'h2, 1'b0, 1'b0);
            push(4'b1110, 4'h1, 1'b0, 1'b0);
        end
        drain();
        // overlay with all digits set to blink: blink must not touch the overlay frames
        a_bcd_i = 16'h1111;
        blink_i = 4'b1111;
        sync(4);
        push(4'b0111, 4'h1, 1'b0, 1'b0);
        push(4'b1011, 4'h1, 1'b0, 1'b0);
        drain();
        req(16'h9876);
        push(4'b1101, 4'h1, 1'b0, 1'b1);
        push(4'b1110, 4'h1, 1'b0, 1'b1);
        push_frame(16'h9876, 1'b1, 1'b1);
        push_frame(16'h9876, 1'b1, 1'b1);
        push_frame(16'h9876, 1'b1, 1'b0);
        push_frame(16'h1111, 1'b0, 1'b0);
        drain();
        // re-request on the final overlay frame-end edge extends the overlay
        blink_i = 4'b0000;
        sync(1);
        push(4'b0111, 4'h1, 1'b0, 1'b0);
        push(4'b1011, 4'h1, 1'b0, 1'b0);
        drain();
        req(16'h9876);
        push(4'b1101, 4'h1, 1'b0, 1'b1);
        push(4'b1110, 4'h1, 1'b0, 1'b1);
        push_frame(16'h9876, 1'b1, 1'b1);
        push_frame(16'h9876, 1'b1, 1'b1);
        push(4'b0111, 4'h6, 1'b0, 1'b1);
        push(4'b1011, 4'h7, 1'b0, 1'b1);
        push(4'b1101, 4'h8, 1'b0, 1'b1);
        drain();
        repeat (3) step();
        b_req_i = 1'b1;
        b_bcd_i = 16'h5555;
        push(4'b1110, 4'h9, 1'b0, 1'b1);
        tick_check();
        b_req_i = 1'b0;
        push_frame(16'h5555, 1'b1, 1'b1);
        push_frame(16'h5555, 1'b1, 1'b1);
        push_frame(16'h5555, 1'b1, 1'b0);
        push_frame(16'h1111, 1'b0, 1'b0);
        drain();
        // reset while an overlay is shown
        sync(1);
        push(4'b0111, 4'h1, 1'b0, 1'b0);
        push(4'b1011, 4'h1, 1'b0, 1'b0);
        drain();
        req(16'h9876);
        push(4'b1101, 4'h1, 1'b0, 1'b1);
        push(4'b1110, 4'h1, 1'b0, 1'b1);
        push(4'b0111, 4'h6, 1'b0, 1'b1);
        push(4'b1011, 4'h7, 1'b0, 1'b1);
        drain();
        do_reset(3);
        push_frame(16'h1111, 1'b0, 1'b0);
        drain();
        // reset while a request is pending: it must be discarded
        push(4'b0111, 4'h1, 1'b0, 1'b0);
        drain();
        req(16'h9876);
        do_reset(2);
        push_frame(16'h1111, 1'b0, 1'b0);
        push_frame(16'h1111, 1'b0, 1'b0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
